// File: rtl/pma_comma_aligner.sv
// Receive comma aligner for the 10-bit PMA path: comma search over a two-beat window, bit shifter, lock/loss sync FSM.
// Optional build macro PMA_ALIGN_LOCK_EN: offset frozen in SYNC, sync dropped after LOSS_CNT misaligned commas.
module pma_comma_aligner #(
  parameter  int SYMS     = 2,
  parameter  int LOCK_CNT = 3,
  parameter  int LOSS_CNT = 4,
  localparam int W        = 10 * SYMS,
  localparam int OFF_W    = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [W-1:0]     rx_data,
  input  logic             align_en,
  output logic             tx_valid,
  output logic [W-1:0]     tx_data,
  output logic [SYMS-1:0]  comma_det,
  output logic             sync,
  output logic [OFF_W-1:0] offset
);

  // state | meaning
  // LOS   | no comma seen since reset or loss; next comma sets the offset
  // ACQ   | offset chosen, counting consecutive aligned commas toward lock
  // SYNC  | locked; aligned commas clear the miss counter
  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } stateT;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

  stateT            state, stateNext;
  logic [OFF_W-1:0] offsetNext;
  logic [3:0]       cnt, cntNext, cntInc;
  logic [3:0]       miss, missNext, missInc;
  logic [W-1:0]     prev;
  logic [2*W-1:0]   win;
  logic [W-1:0]     aligned;
  logic [SYMS-1:0]  laneComma;
  logic [OFF_W-1:0] kc;
  logic             hit;
  logic [3:0]       kcMod, offMod;
  logic             isAligned;

  function automatic logic isComma(input logic [6:0] bits7);
    return (bits7 == 7'b1111100) || (bits7 == 7'b0000011);
  endfunction

  assign win = {rx_data, prev};

  // Scan high to low so the lowest matching position wins.
  always_comb begin
    hit = 1'b0;
    kc  = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (isComma(win[k +: 7])) begin
        hit = 1'b1;
        kc  = OFF_W'(k);
      end
    end
  end

  always_comb begin
    kcMod     = 4'(32'(kc) % 32'd10);
    offMod    = 4'(32'(offset) % 32'd10);
    isAligned = (kcMod == offMod);
    cntInc    = (cnt == 4'd15) ? cnt : cnt + 4'd1;
    missInc   = (miss >= LOSS_LIM) ? miss : miss + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOS;
      offset    <= '0;
      cnt       <= '0;
      miss      <= '0;
      prev      <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      comma_det <= '0;
    end else if (rx_valid) begin
      state     <= stateNext;
      offset    <= offsetNext;
      cnt       <= cntNext;
      miss      <= missNext;
      prev      <= rx_data;
      tx_valid  <= 1'b1;
      tx_data   <= aligned;
      comma_det <= laneComma;
    end else begin
      tx_valid  <= 1'b0;
    end
  end

  always_comb begin
    stateNext  = state;
    offsetNext = offset;
    cntNext    = cnt;
    missNext   = miss;
    if (rx_valid && align_en && hit) begin
      unique case (state)
        LOS: begin
          offsetNext = kc;
          cntNext    = 4'd1;
          stateNext  = ACQ;
        end
        ACQ: begin
          if (isAligned) begin
            cntNext = cntInc;
            if (cntInc >= LOCK_LIM) begin
              stateNext = SYNC;
              missNext  = '0;
            end
          end else begin
            offsetNext = kc;
            cntNext    = 4'd1;
          end
        end
        SYNC: begin
          if (isAligned) begin
            missNext = '0;
          end else begin
            missNext = missInc;
`ifdef PMA_ALIGN_LOCK_EN
            if (missInc >= LOSS_LIM) begin
              stateNext = LOS;
              cntNext   = '0;
              missNext  = '0;
            end
`else
            offsetNext = kc;
            cntNext    = 4'd1;
            stateNext  = ACQ;
`endif
          end
        end
        default: stateNext = LOS;
      endcase
    end
  end

  // The shift uses the offset held before this beat; a new offset takes effect next beat.
  always_comb begin
    aligned = W'(win >> offset);
    for (int i = 0; i < SYMS; i++) begin
      laneComma[i] = isComma(aligned[10*i +: 7]);
    end
    sync = (state == SYNC);
  end

endmodule
